// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared types and helpers for the pic_irq_core interrupt path.
// Revision : 1.0
// ============================================================================
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } pic_state_t;

    function automatic int pic_id_w(input int num_irq);
        return (num_irq < 2) ? 1 : $clog2(num_irq);
    endfunction

    // Level visited i-th when scanning from the highest priority down.
    function automatic int unsigned rot_index(input int unsigned ptr,
                                              input int unsigned i,
                                              input int unsigned num_irq);
        return (ptr + 32'd1 + i) % num_irq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_irq_core_if.sv
`default_nettype none
// ============================================================================
// Module   : pic_irq_core_if
// Purpose  : Request, configuration, INTA/EOI and vector bundle of the core.
// Revision : 1.0
// ============================================================================
interface pic_irq_core_if #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
);
    import pic_pkg::*;

    localparam int ID_W = pic_id_w(NUM_IRQ);

    logic [NUM_IRQ-1:0]    irq_in;
    logic                  cfg_ltim;
    logic                  cfg_aeoi;
    logic                  cfg_rot_aeoi;
    logic [NUM_IRQ-1:0]    imr;
    logic [VEC_W-ID_W-1:0] vec_base;
    logic                  inta_n;
    logic                  eoi_valid;
    logic                  eoi_specific;
    logic                  eoi_rotate;
    logic [ID_W-1:0]       eoi_id;
    logic                  int_out;
    logic                  vec_valid;
    logic [VEC_W-1:0]      vec_out;
    logic [NUM_IRQ-1:0]    irr_out;
    logic [NUM_IRQ-1:0]    isr_out;

    modport master (
        output irq_in, cfg_ltim, cfg_aeoi, cfg_rot_aeoi, imr, vec_base,
               inta_n, eoi_valid, eoi_specific, eoi_rotate, eoi_id,
        input  int_out, vec_valid, vec_out, irr_out, isr_out
    );

    modport slave (
        input  irq_in, cfg_ltim, cfg_aeoi, cfg_rot_aeoi, imr, vec_base,
               inta_n, eoi_valid, eoi_specific, eoi_rotate, eoi_id,
        output int_out, vec_valid, vec_out, irr_out, isr_out
    );

endinterface
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module   : pic_priority_resolver
// Purpose  : Circular-priority winner and top-of-ISR search, fully nested.
// Revision : 1.0
// ============================================================================
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    localparam int ID_W    = pic_id_w(NUM_IRQ)
) (
    input  wire  [NUM_IRQ-1:0] req,
    input  wire  [NUM_IRQ-1:0] isr,
    input  wire  [ID_W-1:0]    pri_ptr,
    output logic               win_valid,
    output logic [ID_W-1:0]    win_id,
    output logic               isr_top_valid,
    output logic [ID_W-1:0]    isr_top_id
);

    logic [ID_W-1:0] w_idx;
    int              w_isr_rank;

    // Scan lowest priority first so the last hit is the highest-priority one.
    always_comb begin
        w_idx         = '0;
        w_isr_rank    = NUM_IRQ;
        isr_top_valid = 1'b0;
        isr_top_id    = '0;
        win_valid     = 1'b0;
        win_id        = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_idx = ID_W'(rot_index(32'(pri_ptr), i, NUM_IRQ));
            if (isr[w_idx]) begin
                isr_top_valid = 1'b1;
                isr_top_id    = w_idx;
                w_isr_rank    = i;
            end
        end
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_idx = ID_W'(rot_index(32'(pri_ptr), i, NUM_IRQ));
            if (req[w_idx] && (i < w_isr_rank)) begin
                win_valid = 1'b1;
                win_id    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pic_irq_core.sv
`default_nettype none
// ============================================================================
// Module   : pic_irq_core
// Purpose  : IRR/IMR/ISR interrupt path with INTA handshake and EOI handling.
// Revision : 1.0
// ============================================================================
module pic_irq_core
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input wire            clk,
    input wire            rst,
    pic_irq_core_if.slave bus
);

    localparam int              ID_W      = pic_id_w(NUM_IRQ);
    localparam logic [1:0]      c_idle    = IDLE;
    localparam logic [1:0]      c_ack1    = ACK1;
    localparam logic [1:0]      c_ack2    = ACK2;
    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] r_irr;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic               r_inta_prev;
    logic [ID_W-1:0]    r_pri_ptr;
    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_id;
    logic               r_id_real;
    logic [VEC_W-1:0]   r_vec;
    logic               r_int;

    logic [NUM_IRQ-1:0] w_req;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_id;
    logic               w_top_valid;
    logic [ID_W-1:0]    w_top_id;
    logic               w_fall;
    logic               w_rise;
    logic [1:0]         w_state_nxt;
    logic               w_ack1;
    logic               w_ack2;
    logic               w_done;
    logic [NUM_IRQ-1:0] w_set_mask;
    logic [NUM_IRQ-1:0] w_irr_clr;
    logic [NUM_IRQ-1:0] w_isr_clr;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [ID_W-1:0]    w_eoi_tgt;
    logic               w_eoi_hit;
    logic [NUM_IRQ-1:0] w_irr_nxt;
    logic [NUM_IRQ-1:0] w_isr_nxt;

    assign w_req  = r_irr & ~bus.imr & ~r_isr;
    assign w_fall = r_inta_prev & ~bus.inta_n;
    assign w_rise = ~r_inta_prev & bus.inta_n;

    pic_priority_resolver #(
        .NUM_IRQ (NUM_IRQ)
    ) u_resolver (
        .req           (w_req),
        .isr           (r_isr),
        .pri_ptr       (r_pri_ptr),
        .win_valid     (w_win_valid),
        .win_id        (w_win_id),
        .isr_top_valid (w_top_valid),
        .isr_top_id    (w_top_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ack1      = 1'b0;
        w_ack2      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_idle: if (w_fall) begin w_state_nxt = c_ack1; w_ack1 = 1'b1; end
            c_ack1: if (w_fall) begin w_state_nxt = c_ack2; w_ack2 = 1'b1; end
            c_ack2: if (w_rise) begin w_state_nxt = c_idle; w_done = 1'b1; end
            default: w_state_nxt = c_idle;
        endcase
    end

    // EOI rotation is applied after AEOI rotation, so it wins a same-cycle tie.
    always_comb begin
        w_set_mask = '0;
        w_irr_clr  = '0;
        w_isr_clr  = '0;
        w_ptr_nxt  = r_pri_ptr;
        if (w_ack1 && w_win_valid) begin
            w_set_mask[w_win_id] = 1'b1;
            w_irr_clr[w_win_id]  = ~bus.cfg_ltim;
        end
        if (w_done && bus.cfg_aeoi && r_id_real) begin
            w_isr_clr[r_id] = 1'b1;
            if (bus.cfg_rot_aeoi) w_ptr_nxt = r_id;
        end
        w_eoi_tgt = bus.eoi_specific ? bus.eoi_id : w_top_id;
        w_eoi_hit = bus.eoi_valid &&
                    (bus.eoi_specific ? r_isr[bus.eoi_id] : w_top_valid);
        if (w_eoi_hit) begin
            w_isr_clr[w_eoi_tgt] = 1'b1;
            if (bus.eoi_rotate) w_ptr_nxt = w_eoi_tgt;
        end
    end

    assign w_irr_nxt = bus.cfg_ltim ? bus.irq_in
                     : ((r_irr | (bus.irq_in & ~r_irq_prev)) & ~w_irr_clr);
    assign w_isr_nxt = (r_isr & ~w_isr_clr) | w_set_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irr       <= '0;
            r_isr       <= '0;
            r_irq_prev  <= '0;
            r_inta_prev <= 1'b1;
            r_pri_ptr   <= c_last_id;
            r_state     <= c_idle;
            r_id        <= c_last_id;
            r_id_real   <= 1'b0;
            r_vec       <= '0;
            r_int       <= 1'b0;
        end else begin
            r_irr       <= w_irr_nxt;
            r_isr       <= w_isr_nxt;
            r_irq_prev  <= bus.irq_in;
            r_inta_prev <= bus.inta_n;
            r_pri_ptr   <= w_ptr_nxt;
            r_state     <= w_state_nxt;
            r_int       <= w_win_valid && (w_state_nxt == c_idle);
            if (w_ack1) begin
                r_id      <= w_win_valid ? w_win_id : c_last_id;
                r_id_real <= w_win_valid;
            end
            if (w_ack2) r_vec <= {bus.vec_base, r_id};
        end
    end

    assign bus.int_out   = r_int;
    assign bus.vec_valid = (r_state == c_ack2);
    assign bus.vec_out   = r_vec;
    assign bus.irr_out   = r_irr;
    assign bus.isr_out   = r_isr;

endmodule
`default_nettype wire

// File: tb/tb_pic_irq_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_irq_core
// Purpose  : Directed scenarios plus random traffic against a rank-based model.
// Revision : 1.0
// ============================================================================
module tb_pic_irq_core;

    localparam int N  = 8;
    localparam int VW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pic_irq_core_if #(.NUM_IRQ(N), .VEC_W(VW)) bus ();

    pic_irq_core #(.NUM_IRQ(N), .VEC_W(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: priority is a rank, 0 = most urgent.
    bit [N-1:0] m_irr, m_isr, m_prev;
    bit         m_inta_prev, m_real, m_int;
    int         m_ptr, m_phase, m_id, m_vec;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int rank_of(input int idx);
        return (idx - m_ptr - 1 + 2 * N) % N;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_prev = '0; m_inta_prev = 1'b1;
        m_ptr = N - 1; m_phase = 0; m_id = N - 1; m_real = 1'b0;
        m_vec = 0; m_int = 1'b0;
    endtask

    task automatic model_step();
        bit [N-1:0] cand, n_irr, clr, setm;
        int best, top, n_ptr, n_phase, tgt;
        bit win, fall, rise;
        if (rst) begin
            model_reset();
            return;
        end
        cand = m_irr & ~bus.imr & ~m_isr;
        best = -1;
        top  = -1;
        for (int k = 0; k < N; k++) begin
            if (cand[k]  && (best < 0 || rank_of(k) < rank_of(best))) best = k;
            if (m_isr[k] && (top  < 0 || rank_of(k) < rank_of(top)))  top  = k;
        end
        win  = (best >= 0) && (top < 0 || rank_of(best) < rank_of(top));
        fall = m_inta_prev && !bus.inta_n;
        rise = !m_inta_prev && bus.inta_n;
        n_irr = bus.cfg_ltim ? bus.irq_in : (m_irr | (bus.irq_in & ~m_prev));
        clr = '0; setm = '0; n_ptr = m_ptr; n_phase = m_phase;
        if (m_phase == 0 && fall) begin
            n_phase = 1;
            if (win) begin
                m_id = best; m_real = 1'b1; setm[best] = 1'b1;
                if (!bus.cfg_ltim) n_irr[best] = 1'b0;
            end else begin
                m_id = N - 1; m_real = 1'b0;
            end
        end else if (m_phase == 1 && fall) begin
            n_phase = 2;
            m_vec = bus.vec_base * N + m_id;
        end else if (m_phase == 2 && rise) begin
            n_phase = 0;
            if (bus.cfg_aeoi && m_real) begin
                clr[m_id] = 1'b1;
                if (bus.cfg_rot_aeoi) n_ptr = m_id;
            end
        end
        if (bus.eoi_valid) begin
            tgt = bus.eoi_specific ? int'(bus.eoi_id) : top;
            if (tgt >= 0 && m_isr[tgt]) begin
                clr[tgt] = 1'b1;
                if (bus.eoi_rotate) n_ptr = tgt;
            end
        end
        m_int       = win && (n_phase == 0);
        m_irr       = n_irr;
        m_isr       = (m_isr & ~clr) | setm;
        m_prev      = bus.irq_in;
        m_inta_prev = bus.inta_n;
        m_ptr       = n_ptr;
        m_phase     = n_phase;
    endtask

    task automatic cyc(input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            #1;
            check_val("m_int", bus.int_out, m_int);
            check_val("m_vv", bus.vec_valid, m_phase == 2);
            check_val("m_vec", bus.vec_out, m_vec);
            check_val("m_irr", bus.irr_out, m_irr);
            check_val("m_isr", bus.isr_out, m_isr);
        end
    endtask

    task automatic do_reset();
        bus.irq_in = '0; bus.imr = '0; bus.inta_n = 1'b1; bus.eoi_valid = 1'b0;
        bus.cfg_ltim = 1'b0; bus.cfg_aeoi = 1'b0; bus.cfg_rot_aeoi = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic pulse_irq(input logic [N-1:0] v);
        bus.irq_in = v; cyc(1);
        bus.irq_in = '0; cyc(1);
    endtask

    task automatic inta(input logic v);
        bus.inta_n = v; cyc(1);
    endtask

    task automatic eoi_ns();
        bus.eoi_specific = 1'b0; bus.eoi_rotate = 1'b0; bus.eoi_valid = 1'b1;
        cyc(1);
        bus.eoi_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.vec_base = 5'h08; bus.eoi_specific = 1'b0; bus.eoi_rotate = 1'b0; bus.eoi_id = '0;
        do_reset();
        check_val("rst_int", bus.int_out, 0);
        check_val("rst_vv", bus.vec_valid, 0);
        check_val("rst_isr", bus.isr_out, 0);

        // Edge mode, fixed priority
        pulse_irq(8'h24);
        check_val("t1_int", bus.int_out, 1);
        inta(0);
        check_val("t1_isr", bus.isr_out, 8'h04);
        check_val("t1_irr", bus.irr_out, 8'h20);
        inta(1); inta(0);
        check_val("t1_vec", bus.vec_out, 8'h42);
        check_val("t1_vv", bus.vec_valid, 1);
        inta(1);
        eoi_ns();
        check_val("t1_eoi", bus.isr_out, 8'h00);
        cyc(1);
        check_val("t1_int5", bus.int_out, 1);

        // Nesting
        do_reset();
        pulse_irq(8'h08);
        inta(0); inta(1); inta(0); inta(1);
        pulse_irq(8'h42);
        check_val("t2_int", bus.int_out, 1);
        inta(0);
        check_val("t2_isr", bus.isr_out, 8'h0A);
        inta(1); inta(0);
        check_val("t2_vec", bus.vec_out, 8'h41);
        inta(1); cyc(2);
        check_val("t2_int6", bus.int_out, 0);
        eoi_ns(); cyc(1);
        check_val("t2_irr", bus.irr_out, 8'h40);
        check_val("t2_int6b", bus.int_out, 0);
        eoi_ns(); cyc(1);
        check_val("t2_int6c", bus.int_out, 1);

        // AEOI with rotation
        do_reset();
        bus.cfg_aeoi = 1'b1; bus.cfg_rot_aeoi = 1'b1;
        pulse_irq(8'h01);
        inta(0); inta(1); inta(0); inta(1);
        check_val("t3_isr0", bus.isr_out, 8'h00);
        pulse_irq(8'h81);
        inta(0);
        check_val("t3_isr7", bus.isr_out, 8'h80);
        inta(1); inta(0);
        check_val("t3_vec", bus.vec_out, 8'h47);
        inta(1);
        check_val("t3_isr1", bus.isr_out, 8'h00);

        // Masked request, spurious acknowledge
        do_reset();
        bus.imr = 8'hFF;
        pulse_irq(8'h01); cyc(1);
        check_val("t4_int", bus.int_out, 0);
        check_val("t4_irr", bus.irr_out, 8'h01);
        inta(0); inta(1); inta(0);
        check_val("t4_vec", bus.vec_out, 8'h47);
        inta(1);
        check_val("t4_isr", bus.isr_out, 8'h00);

        // Level mode
        do_reset();
        bus.cfg_ltim = 1'b1; bus.irq_in = 8'h04;
        cyc(2);
        check_val("t5_int", bus.int_out, 1);
        inta(0);
        check_val("t5_irr", bus.irr_out, 8'h04);
        check_val("t5_isr", bus.isr_out, 8'h04);
        inta(1); inta(0);
        check_val("t5_vec", bus.vec_out, 8'h42);
        inta(1);
        eoi_ns(); cyc(1);
        bus.irq_in = 8'h00; cyc(1);
        inta(0);
        check_val("t5_spur_isr", bus.isr_out, 8'h00);
        inta(1); inta(0);
        check_val("t5_spur_vec", bus.vec_out, 8'h47);
        inta(1);

        // Reset in ACK2
        do_reset();
        pulse_irq(8'h10);
        inta(0); inta(1); inta(0);
        check_val("t6_vv1", bus.vec_valid, 1);
        bus.inta_n = 1'b1; rst = 1'b1; cyc(1); rst = 1'b0;
        check_val("t6_vv0", bus.vec_valid, 0);
        check_val("t6_isr", bus.isr_out, 8'h00);
        pulse_irq(8'h02);
        inta(0);
        check_val("t6_ack1", bus.isr_out, 8'h02);
        inta(1); inta(0);
        check_val("t6_vec", bus.vec_out, 8'h41);
        inta(1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.inta_n = ~bus.inta_n;
            bus.irq_in = bus.irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 31) == 0) bus.imr = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                bus.cfg_ltim     = 1'($urandom);
                bus.cfg_aeoi     = 1'($urandom);
                bus.cfg_rot_aeoi = 1'($urandom);
            end
            bus.eoi_valid    = ($urandom_range(0, 7) == 0);
            bus.eoi_specific = 1'($urandom);
            bus.eoi_rotate   = 1'($urandom);
            bus.eoi_id       = 3'($urandom);
            bus.vec_base     = 5'($urandom);
            rst              = ($urandom_range(0, 299) == 0);
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_irq_core.md
Name: pic_irq_core

Overview:
- Parametrised, fully synchronous successor to the 8259-style control/interrupt path.
- Latches NUM_IRQ request lines into the IRR, applies the IMR, and resolves priority (fixed or rotating, fully nested against the ISR).
- Drives INT and runs the two-pulse INTA handshake that returns a vector; handles specific, non-specific and automatic EOI.
- Sits between the register/ICW-decode front end, which supplies the cfg_*/imr/eoi inputs, and the data bus buffer, which consumes vec_* and the irr/isr read-back.

Parameters:
- NUM_IRQ, 8, number of request lines; power of two, range 2..64.
- VEC_W, 8, vector width; must satisfy VEC_W > ID_W.
- ID_W, $clog2(NUM_IRQ), derived width of an IRQ index; not overridden.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw request lines, already synchronised to clk.
- cfg_ltim  in  1  1 = level triggered, 0 = rising-edge triggered.
- cfg_aeoi  in  1  1 = automatic EOI at end of the INTA sequence.
- cfg_rot_aeoi  in  1  1 = rotate priority on automatic EOI.
- imr  in  NUM_IRQ  mask; bit = 1 blocks that IRQ from resolution (its IRR bit still latches).
- vec_base  in  VEC_W-ID_W  upper vector bits (ICW2 equivalent).
- inta_n  in  1  active-low acknowledge, sampled on clk.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific EOI.
- eoi_rotate  in  1  1 = rotate priority on this EOI.
- eoi_id  in  ID_W  target level for specific EOI.
- int_out  out  1  interrupt request to the CPU.
- vec_valid  out  1  vector is valid on vec_out.
- vec_out  out  VEC_W  {vec_base, id}.
- irr_out  out  NUM_IRQ  IRR read-back.
- isr_out  out  NUM_IRQ  ISR read-back.

Behaviour:
- Reset: IRR, ISR, irq_prev and the vec_out register are all zero; inta_prev = 1; pri_ptr = NUM_IRQ-1, so IRQ0 has highest priority; state = IDLE; int_out = 0; vec_valid = 0.
- Edge mode: IRR bit sets on a 0->1 transition of irq_in against the registered irq_prev. The bit clears at ACK1 when it is the winner; otherwise it holds until then.
- Level mode: IRR = irq_in each cycle, registered. The winner bit is not cleared at ACK1.
- Priority order is circular, starting at (pri_ptr+1) mod NUM_IRQ.
- Candidate set = IRR & ~imr & ~ISR. A candidate wins only if it has strictly higher priority than the highest-priority set ISR bit (fully nested).
- int_out is registered and equals (winner exists), one cycle after the IRR update. It is forced to 0 in ACK1 and ACK2.
- INTA edges come from the registered inta_prev: fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
- FSM states IDLE, ACK1, ACK2:
  - IDLE -> ACK1 on fall. Capture id = winner and set ISR[id]. If there is no winner (spurious), id = NUM_IRQ-1 and ISR is not set.
  - ACK1 -> ACK2 on the next fall. vec_out = {vec_base, id}; vec_valid = 1 while in ACK2.
  - ACK2 -> IDLE on rise. If cfg_aeoi, clear ISR[id]; if cfg_rot_aeoi is also set, pri_ptr = id.
  - Rises seen in ACK1 are ignored.
- Spurious acknowledge: the ISR is never set, so AEOI clears nothing.
- Non-specific EOI clears the highest-priority set ISR bit. If no ISR bit is set, it is a no-op.
- Specific EOI clears ISR[eoi_id].
- eoi_rotate with an effective clear sets pri_ptr = the cleared id.
- EOI simultaneous with the ACK1 ISR set: the set applies to id, the clear applies to its own target, and both take effect in the same cycle. If both target the same bit, the set wins.
- EOI has no effect on the FSM state.
- rst asserted in any state returns to the reset values on the next edge, including mid-handshake. vec_valid drops in that cycle.
- The imr change takes effect in the next resolution cycle. An already-set ISR bit is unaffected by masking.
- irr_out/isr_out are direct register outputs, zero latency.

Decomposition:
- Package pic_pkg:
  - state enum pic_state_t {IDLE, ACK1, ACK2};
  - localparam helper for ID_W;
  - function rot_index(ptr, i).
- Sub-module pic_priority_resolver #(NUM_IRQ), purely combinational:
  - inputs: req, isr, pri_ptr;
  - outputs: win_valid, win_id, isr_top_valid, isr_top_id.
  - The same block serves both winner selection and the non-specific EOI target.

Test Plan:
- Edge, fixed priority: pulse irq_in = 8'h24, then two inta_n low pulses. Required: int_out = 1 two cycles after the pulse; after ACK1, isr_out = 8'h04 and irr_out = 8'h20; vec_base = 5'h08 gives vec_out = 8'h42. Non-specific EOI then gives isr_out = 0 and int_out re-asserts for IRQ5.
- Nesting: IRQ3 in service, then raise IRQ1 and IRQ6. Required: int_out = 1 for IRQ1 only; after servicing it, ISR = 8'h0A and IRQ6 stays pending until both EOIs.
- AEOI + rotate: cfg_aeoi = cfg_rot_aeoi = 1; service IRQ0, then raise IRQ0 and IRQ7 together. Required: the next vector id = 7, and isr_out = 0 after each ACK2 rise.
- Mask and spurious: imr = 8'hFF with irq_in = 8'h01, then an INTA pair. Required: int_out = 0; vec_out low bits = 3'b111; isr_out = 0.
- Level mode: hold irq_in[2] = 1 through ACK1. Required: irr_out[2] stays 1; dropping the line before ACK1 removes the request and gives a spurious id of 7.
- Reset in ACK2: assert rst while vec_valid = 1. Required: next cycle vec_valid = 0, isr_out = 0, state IDLE, and the first fall afterwards is treated as a new ACK1.
